// File: rtl/hba_arb_pkg.sv
// Shared types and constants for the HBA bus round-robin arbiter.
package hba_arb_pkg;

  localparam int unsigned HBA_NUM_MASTERS = 4;
  localparam int unsigned HBA_MIDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER
  } arb_state_e;

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational rotate-priority picker: first requester found searching
// upward from last_winner+1, wrapping modulo the master count.
module hba_rr_pick
  import hba_arb_pkg::*;
(
  input  logic [HBA_NUM_MASTERS-1:0] req,
  input  logic [HBA_MIDX_W-1:0]      last_winner,
  output logic [HBA_MIDX_W-1:0]      winner,
  output logic                       valid
);

  logic [HBA_MIDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // Offset HBA_NUM_MASTERS wraps back to last_winner itself (lowest priority).
    for (int unsigned i = 1; i <= HBA_NUM_MASTERS; i++) begin
      idx = last_winner + HBA_MIDX_W'(i);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hba_rr_arbiter.sv
// Round-robin HBA bus arbiter with tenure limit and transfer watchdog that
// issues a synthetic acknowledge when no slave responds.
module hba_rr_arbiter
  import hba_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = HBA_NUM_MASTERS,
  parameter int unsigned MAX_XFERS   = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   hba_clk,
  input  logic                   hba_reset,
  input  logic [NUM_MASTERS-1:0] hba_mrequest,
  input  logic                   hba_select,
  input  logic                   hba_xferack,
  output logic [NUM_MASTERS-1:0] hba_mgrant,
  output logic                   hba_xferack_timeout,
  output logic                   bus_timeout,
  output logic [HBA_MIDX_W-1:0]  timeout_master,
  output logic [7:0]             timeout_count
);

  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned XCNT_W = (MAX_XFERS == 0) ? 1 : $clog2(MAX_XFERS + 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [XCNT_W-1:0] XCNT_LIMIT = XCNT_W'(MAX_XFERS);

  arb_state_e            state;
  logic [HBA_MIDX_W-1:0] last_winner;
  logic [WD_W-1:0]       wd;
  logic [XCNT_W-1:0]     xfer_cnt;
  logic                  timeout_pulse;

  logic [HBA_MIDX_W-1:0] pick_winner;
  logic                  pick_valid;
  logic                  ack_seen;
  logic                  others_pending;
  logic                  rotate_due;

  hba_rr_pick u_pick (
    .req         (hba_mrequest),
    .last_winner (last_winner),
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  // A real ack coinciding with the synthetic one is the same transfer.
  assign ack_seen       = hba_xferack | timeout_pulse;
  assign others_pending = |(hba_mrequest & ~hba_mgrant);
  assign rotate_due     = (MAX_XFERS != 0) && (xfer_cnt >= XCNT_LIMIT) && others_pending;

  assign hba_xferack_timeout = timeout_pulse;
  assign bus_timeout         = timeout_pulse;

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state          <= IDLE;
      hba_mgrant     <= '0;
      last_winner    <= HBA_MIDX_W'(HBA_NUM_MASTERS - 1);
      wd             <= '0;
      xfer_cnt       <= '0;
      timeout_pulse  <= 1'b0;
      timeout_master <= '0;
      timeout_count  <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          hba_mgrant <= '0;
          if (pick_valid) begin
            hba_mgrant  <= NUM_MASTERS'(1) << pick_winner;
            last_winner <= pick_winner;
            xfer_cnt    <= '0;
            state       <= GRANT;
          end
        end

        GRANT: begin
          if (hba_select) begin
            // The first select cycle already counts toward the watchdog.
            state <= XFER;
            if (hba_xferack) begin
              wd <= '0;
              if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + XCNT_W'(1);
            end else begin
              wd <= WD_W'(1);
            end
          end else if (!hba_mrequest[last_winner] || rotate_due) begin
            hba_mgrant <= '0;
            state      <= IDLE;
          end
        end

        XFER: begin
          if (ack_seen) begin
            wd <= '0;
            if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + XCNT_W'(1);
          end else if (hba_select) begin
            if (wd == WD_LAST) begin
              wd             <= '0;
              timeout_pulse  <= 1'b1;
              timeout_master <= last_winner;
              if (timeout_count != '1) timeout_count <= timeout_count + 8'd1;
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
          if (!hba_select) state <= GRANT;
        end

        default: begin
          hba_mgrant <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hba_rr_arbiter.sv
// Self-checking bench for hba_rr_arbiter: vector table, directed corner
// sequences, then randomized traffic against a behavioural model.
module tb_hba_rr_arbiter;

  localparam int unsigned TMO  = 16;
  localparam int unsigned MAXX = 2;

  logic       hba_clk = 1'b0;
  logic       hba_reset;
  logic [3:0] hba_mrequest;
  logic       hba_select;
  logic       hba_xferack;
  logic [3:0] hba_mgrant;
  logic       hba_xferack_timeout;
  logic       bus_timeout;
  logic [1:0] timeout_master;
  logic [7:0] timeout_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 hba_clk = ~hba_clk;

  hba_rr_arbiter #(
    .NUM_MASTERS (4),
    .MAX_XFERS   (MAXX),
    .TIMEOUT     (TMO)
  ) dut (
    .hba_clk             (hba_clk),
    .hba_reset           (hba_reset),
    .hba_mrequest        (hba_mrequest),
    .hba_select          (hba_select),
    .hba_xferack         (hba_xferack),
    .hba_mgrant          (hba_mgrant),
    .hba_xferack_timeout (hba_xferack_timeout),
    .bus_timeout         (bus_timeout),
    .timeout_master      (timeout_master),
    .timeout_count       (timeout_count)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       sel;
    logic       ack;
    logic [3:0] exp_grant;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: owner index (-1 = bus free), transfer phase flag,
  // consecutive unacked select cycles, acks in the current tenure.
  int m_owner, m_ptr, m_run, m_tenure, m_tmaster, m_tcount;
  bit m_xfer, m_syn;

  task automatic model_cycle(input bit rst, input bit [3:0] req, input bit sel, input bit ack);
    bit acked;
    bit fire;
    fire = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = 3; m_run = 0; m_tenure = 0;
      m_tmaster = 0; m_tcount = 0; m_xfer = 1'b0; m_syn = 1'b0;
      return;
    end
    acked = ack || m_syn;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_ptr = c; m_tenure = 0;
        end
      end
    end else if (m_xfer || sel) begin
      if (!m_xfer) m_run = 0;
      if (acked) begin
        m_tenure++;
        m_run = 0;
      end else if (sel) begin
        m_run++;
        if (m_run == TMO) begin
          fire = 1'b1;
          m_run = 0;
          m_tmaster = m_owner;
          if (m_tcount < 255) m_tcount++;
        end
      end
      m_xfer = sel;
    end else if (!req[m_owner] ||
                 (MAXX > 0 && m_tenure >= MAXX && (req & ~(4'b0001 << m_owner)) != 4'b0000)) begin
      m_owner = -1;
    end
    m_syn = fire;
  endtask

  function automatic logic [3:0] model_grant();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] req, input logic sel, input logic ack);
    hba_reset    = rst;
    hba_mrequest = req;
    hba_select   = sel;
    hba_xferack  = ack;
    model_cycle(rst, req, sel, ack);
    @(posedge hba_clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] eg, input logic eto);
    check({name, ".grant"}, 32'(hba_mgrant), 32'(eg));
    check({name, ".xack_to"}, 32'(hba_xferack_timeout), 32'(eto));
    check({name, ".bus_to"}, 32'(bus_timeout), 32'(eto));
  endtask

  function automatic vec_t mk(logic rst, logic [3:0] req, logic sel, logic ack,
                              logic [3:0] eg, logic eto);
    vec_t v;
    v.rst = rst; v.req = req; v.sel = sel; v.ack = ack;
    v.exp_grant = eg; v.exp_to = eto;
    return v;
  endfunction

  logic [3:0] rreq;
  logic       rsel, rack, rrst;
  int         ack_pct;

  initial begin
    hba_reset = 1'b1; hba_mrequest = '0; hba_select = 1'b0; hba_xferack = 1'b0;

    // Single master request/release, then four-way rotation with dead cycles.
    vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b0100, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 4'b0001, 0));
    for (int m = 0; m < 4; m++) begin
      logic [3:0] g, gn;
      g  = 4'b0001 << m;
      gn = 4'b0001 << ((m + 1) % 4);
      vecs.push_back(mk(0, 4'b1111, 1, 0, g, 0));
      vecs.push_back(mk(0, 4'b1111, 1, 1, g, 0));
      vecs.push_back(mk(0, 4'b1111, 0, 0, g, 0));
      vecs.push_back(mk(0, 4'b1111 & ~g, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b1111, 0, 0, gn, 0));
    end

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].sel, vecs[i].ack);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_to);
    end
    check("reset.tcount", 32'(timeout_count), 32'd0);

    // Forced rotation after MAXX acked transfers.
    step(1, 4'b0000, 0, 0);
    step(0, 4'b1010, 0, 0); chk_out("rot.g1", 4'b0010, 0);
    step(0, 4'b1010, 1, 0); chk_out("rot.sel", 4'b0010, 0);
    step(0, 4'b1010, 1, 1); chk_out("rot.ack1", 4'b0010, 0);
    step(0, 4'b1010, 1, 1); chk_out("rot.ack2", 4'b0010, 0);
    step(0, 4'b1010, 0, 0); chk_out("rot.selLow", 4'b0010, 0);
    step(0, 4'b1010, 0, 0); chk_out("rot.drop", 4'b0000, 0);
    step(0, 4'b1010, 0, 0); chk_out("rot.g3", 4'b1000, 0);

    // Watchdog expiry: pulse exactly TMO cycles after select rises.
    step(1, 4'b0000, 0, 0);
    step(0, 4'b0001, 0, 0); chk_out("wd.grant", 4'b0001, 0);
    for (int j = 1; j <= 20; j++) begin
      step(0, 4'b0001, 1, 0);
      chk_out($sformatf("wd.j%0d", j), 4'b0001, (j == TMO));
      if (j == TMO) begin
        check("wd.tmaster", 32'(timeout_master), 32'd0);
        check("wd.tcount", 32'(timeout_count), 32'd1);
      end
    end
    step(0, 4'b0001, 0, 0); chk_out("wd.end", 4'b0001, 0);

    // Real ack at expiry wins; tenure count must be exactly one afterwards.
    step(0, 4'b0000, 0, 0); chk_out("race.rel", 4'b0000, 0);
    step(0, 4'b0101, 0, 0); chk_out("race.g2", 4'b0100, 0);
    for (int j = 1; j <= 20; j++) begin
      step(0, 4'b0101, 1, (j == TMO));
      chk_out($sformatf("race.j%0d", j), 4'b0100, 0);
    end
    step(0, 4'b0101, 0, 0); chk_out("race.selLow", 4'b0100, 0);
    step(0, 4'b0101, 0, 0); chk_out("race.hold", 4'b0100, 0);
    step(0, 4'b0101, 1, 0); chk_out("race.sel2", 4'b0100, 0);
    step(0, 4'b0101, 1, 1); chk_out("race.ack2", 4'b0100, 0);
    step(0, 4'b0101, 0, 0); chk_out("race.selLow2", 4'b0100, 0);
    step(0, 4'b0101, 0, 0); chk_out("race.rot", 4'b0000, 0);
    step(0, 4'b0101, 0, 0); chk_out("race.g0", 4'b0001, 0);
    check("race.tcount", 32'(timeout_count), 32'd1);
    check("race.tmaster", 32'(timeout_master), 32'd0);

    // Timeout on master 2, then reset mid-transfer.
    step(1, 4'b0000, 0, 0);
    step(0, 4'b0100, 0, 0); chk_out("rst.g2", 4'b0100, 0);
    for (int j = 1; j <= TMO; j++) begin
      step(0, 4'b0100, 1, 0);
      chk_out($sformatf("rst.j%0d", j), 4'b0100, (j == TMO));
    end
    check("rst.tmaster2", 32'(timeout_master), 32'd2);
    check("rst.tcount1", 32'(timeout_count), 32'd1);
    step(0, 4'b0100, 1, 0);
    step(1, 4'b0101, 1, 0); chk_out("rst.mid", 4'b0000, 0);
    check("rst.tmaster0", 32'(timeout_master), 32'd0);
    check("rst.tcount0", 32'(timeout_count), 32'd0);
    step(0, 4'b0101, 0, 0); chk_out("rst.first", 4'b0001, 0);

    // Randomized traffic against the model.
    rreq = 4'b0000;
    ack_pct = 30;
    step(1, 4'b0000, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 0 : 30;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) rreq[b] = ~rreq[b];
      rsel = (m_owner >= 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
      rack = rsel && ($urandom_range(0, 99) < ack_pct);
      rrst = ($urandom_range(0, 499) == 0);
      step(rrst, rreq, rsel, rack);
      check("rnd.grant", 32'(hba_mgrant), 32'(model_grant()));
      check("rnd.xack_to", 32'(hba_xferack_timeout), 32'(m_syn));
      check("rnd.bus_to", 32'(bus_timeout), 32'(m_syn));
      check("rnd.tmaster", 32'(timeout_master), 32'(m_tmaster));
      check("rnd.tcount", 32'(timeout_count), 32'(m_tcount));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
